// File: rtl/exp4_trena_rx_medida_pkg.sv
// ============================================================================
// Module   : exp4_trena_rx_medida_pkg
// Purpose  : State codes and ASCII constants for the trena serial receiver.
// Revision : 1.0
// ============================================================================
`default_nettype none

package exp4_trena_rx_medida_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    ESPERA_D0   = 4'd1,
    ESPERA_D1   = 4'd2,
    ESPERA_D2   = 4'd3,
    ESPERA_TERM = 4'd4,
    PRONTO      = 4'd5,
    ERRO        = 4'd6
  } estado_t;

  localparam logic [6:0] c_ASCII_0    = 7'h30;
  localparam logic [6:0] c_ASCII_9    = 7'h39;
  localparam logic [6:0] c_ASCII_TERM = 7'h23;

  function automatic logic eh_digito(input logic [6:0] c);
    return (c >= c_ASCII_0) && (c <= c_ASCII_9);
  endfunction

endpackage

`default_nettype wire

// File: rtl/exp4_trena_rx_medida.sv
// ============================================================================
// Module   : exp4_trena_rx_medida
// Purpose  : Assembles "DDD#" ASCII frames into a 3-digit BCD measurement.
// Revision : 1.0
// ============================================================================
`default_nettype none

module exp4_trena_rx_medida
  import exp4_trena_rx_medida_pkg::*;
#(
  parameter int         TIMEOUT_CICLOS = 500_000,
  parameter logic [6:0] TERMINADOR     = c_ASCII_TERM
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  dado_recebido,
  input  logic        pronto_recepcao,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        erro,
  output logic [3:0]  db_erros,
  output logic [3:0]  db_estado
);

  localparam int                 c_CNT_W   = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT_CICLOS - 1);

  estado_t            r_estado;
  estado_t            w_proximo;
  logic [3:0]         r_centenas;
  logic [3:0]         r_dezenas;
  logic [3:0]         r_unidades;
  logic [11:0]        r_medida;
  logic [3:0]         r_erros;
  logic [c_CNT_W-1:0] r_cnt;

  logic w_digito;
  logic w_term;
  logic w_conta_ativa;
  logic w_timeout;
  logic w_ld_c;
  logic w_ld_d;
  logic w_ld_u;
  logic w_ld_medida;

  assign w_digito      = eh_digito(dado_recebido);
  assign w_term        = (dado_recebido == TERMINADOR);
  assign w_conta_ativa = (r_estado == ESPERA_D1) || (r_estado == ESPERA_D2) ||
                         (r_estado == ESPERA_TERM);
  // A character arriving on the last allowed cycle beats the timeout.
  assign w_timeout     = w_conta_ativa && (r_cnt == c_CNT_MAX) && !pronto_recepcao;

  always_comb begin
    w_proximo   = r_estado;
    w_ld_c      = 1'b0;
    w_ld_d      = 1'b0;
    w_ld_u      = 1'b0;
    w_ld_medida = 1'b0;
    case (r_estado)
      INICIAL: w_proximo = ESPERA_D0;
      // PRONTO and ERRO evaluate incoming characters like ESPERA_D0 so none is lost.
      ESPERA_D0, PRONTO, ERRO: begin
        w_proximo = ESPERA_D0;
        if (pronto_recepcao) begin
          if (w_digito) begin
            w_ld_c    = 1'b1;
            w_proximo = ESPERA_D1;
          end else if (!w_term) begin
            w_proximo = ERRO;
          end
        end
      end
      ESPERA_D1: begin
        if (pronto_recepcao) begin
          if (w_digito) begin
            w_ld_d    = 1'b1;
            w_proximo = ESPERA_D2;
          end else begin
            w_proximo = ERRO;
          end
        end else if (w_timeout) begin
          w_proximo = ERRO;
        end
      end
      ESPERA_D2: begin
        if (pronto_recepcao) begin
          if (w_digito) begin
            w_ld_u    = 1'b1;
            w_proximo = ESPERA_TERM;
          end else begin
            w_proximo = ERRO;
          end
        end else if (w_timeout) begin
          w_proximo = ERRO;
        end
      end
      ESPERA_TERM: begin
        if (pronto_recepcao) begin
          if (w_term) begin
            w_ld_medida = 1'b1;
            w_proximo   = PRONTO;
          end else begin
            w_proximo = ERRO;
          end
        end else if (w_timeout) begin
          w_proximo = ERRO;
        end
      end
      default: w_proximo = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= INICIAL;
    end else begin
      r_estado <= w_proximo;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_centenas <= 4'h0;
      r_dezenas  <= 4'h0;
      r_unidades <= 4'h0;
    end else if (r_estado == INICIAL) begin
      r_centenas <= 4'h0;
      r_dezenas  <= 4'h0;
      r_unidades <= 4'h0;
    end else begin
      if (w_ld_c) r_centenas <= dado_recebido[3:0];
      if (w_ld_d) r_dezenas  <= dado_recebido[3:0];
      if (w_ld_u) r_unidades <= dado_recebido[3:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (pronto_recepcao || !w_conta_ativa) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Loaded on the terminator edge so medida and pronto appear in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_medida <= 12'h000;
    end else if (w_ld_medida) begin
      r_medida <= {r_centenas, r_dezenas, r_unidades};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_erros <= 4'h0;
    end else if ((w_proximo == ERRO) && (r_erros != 4'hF)) begin
      r_erros <= r_erros + 4'h1;
    end
  end

  assign medida    = r_medida;
  assign pronto    = (r_estado == PRONTO);
  assign erro      = (r_estado == ERRO);
  assign db_erros  = r_erros;
  assign db_estado = (r_estado > ERRO) ? 4'hF : r_estado;

endmodule

`default_nettype wire

// File: tb/tb_exp4_trena_rx_medida.sv
// ============================================================================
// Module   : tb_exp4_trena_rx_medida
// Purpose  : Directed and random frames checked against a frame-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_exp4_trena_rx_medida;

  localparam int c_TO = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  dado_recebido = 7'h00;
  logic        pronto_recepcao = 1'b0;
  logic [11:0] medida;
  logic        pronto;
  logic        erro;
  logic [3:0]  db_erros;
  logic [3:0]  db_estado;

  int checks   = 0;
  int failures = 0;

  // Frame-level reference: digits collected so far, idle cycles, results.
  int          m_ndig;
  int          m_idle;
  int          m_erros;
  logic [3:0]  m_dig [3];
  logic [11:0] m_medida;
  bit          m_pronto;
  bit          m_erro;

  exp4_trena_rx_medida #(.TIMEOUT_CICLOS(c_TO), .TERMINADOR(7'h23)) dut (
    .clock           (clock),
    .reset           (reset),
    .dado_recebido   (dado_recebido),
    .pronto_recepcao (pronto_recepcao),
    .medida          (medida),
    .pronto          (pronto),
    .erro            (erro),
    .db_erros        (db_erros),
    .db_estado       (db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ndig = 0; m_idle = 0; m_erros = 0; m_medida = 12'h000;
    m_pronto = 0; m_erro = 0;
    for (int i = 0; i < 3; i++) m_dig[i] = 4'h0;
  endtask

  task automatic model_step(input bit v, input logic [6:0] ch);
    bit dig;
    bit p;
    bit e;
    dig = (ch >= 7'h30) && (ch <= 7'h39);
    p = 0;
    e = 0;
    if (v) begin
      m_idle = 0;
      if (m_ndig == 0) begin
        if (dig) begin m_dig[0] = ch[3:0]; m_ndig = 1; end
        else if (ch != 7'h23) e = 1;
      end else if (m_ndig < 3) begin
        if (dig) begin m_dig[m_ndig] = ch[3:0]; m_ndig++; end
        else begin e = 1; m_ndig = 0; end
      end else begin
        if (ch == 7'h23) begin p = 1; m_medida = {m_dig[0], m_dig[1], m_dig[2]}; end
        else e = 1;
        m_ndig = 0;
      end
    end else if (m_ndig > 0) begin
      if (m_idle == c_TO - 1) begin e = 1; m_ndig = 0; m_idle = 0; end
      else m_idle++;
    end else begin
      m_idle = 0;
    end
    if (e && m_erros < 15) m_erros++;
    m_pronto = p;
    m_erro   = e;
  endtask

  function automatic logic [3:0] model_estado();
    if (m_pronto) return 4'd5;
    if (m_erro)   return 4'd6;
    return 4'(m_ndig + 1);
  endfunction

  task automatic tick(input bit v, input logic [6:0] ch);
    logic [31:0] obs;
    logic [31:0] exp;
    pronto_recepcao = v;
    dado_recebido   = ch;
    @(posedge clock);
    model_step(v, ch);
    #1;
    pronto_recepcao = 1'b0;
    dado_recebido   = 7'h00;
    obs = {10'd0, pronto, erro, medida, db_erros, db_estado};
    exp = {10'd0, m_pronto, m_erro, m_medida, 4'(m_erros), model_estado()};
    chk("ciclo", obs, exp);
  endtask

  task automatic send(input logic [6:0] ch, input int gap);
    tick(1'b1, ch);
    repeat (gap) tick(1'b0, 7'h00);
  endtask

  initial begin
    logic [6:0] ch;
    model_reset();
    #12;
    chk("reset_medida", 32'(medida), 32'h000);
    chk("reset_estado", 32'(db_estado), 32'h0);
    chk("reset_flags", {30'd0, pronto, erro}, 32'h0);
    chk("reset_erros", 32'(db_erros), 32'h0);
    reset = 1'b1;
    tick(1'b0, 7'h00);

    // Frame 1 2 3 #
    send(7'h31, 10); send(7'h32, 10); send(7'h33, 10);
    tick(1'b1, 7'h23);
    chk("t1_pronto", 32'(pronto), 32'h1);
    chk("t1_medida", 32'(medida), 32'h123);
    repeat (3) tick(1'b0, 7'h00);

    // Bad character mid-frame
    send(7'h30, 2); send(7'h34, 2);
    tick(1'b1, 7'h58);
    chk("t2_erro", 32'(erro), 32'h1);
    tick(1'b0, 7'h00);
    chk("t2_erros", 32'(db_erros), 32'h1);
    chk("t2_medida", 32'(medida), 32'h123);

    // Timeout after two digits
    send(7'h37, 1);
    tick(1'b1, 7'h38);
    repeat (c_TO - 1) tick(1'b0, 7'h00);
    chk("t3_sem_erro", 32'(erro), 32'h0);
    tick(1'b0, 7'h00);
    chk("t3_erro", 32'(erro), 32'h1);
    tick(1'b0, 7'h00);
    chk("t3_estado", 32'(db_estado), 32'h1);

    // Stray '#', 999, then a digit on the PRONTO cycle
    send(7'h23, 3); send(7'h39, 3); send(7'h39, 3); send(7'h39, 3);
    tick(1'b1, 7'h23);
    chk("t4_medida", 32'(medida), 32'h999);
    tick(1'b1, 7'h35);
    chk("t4_estado", 32'(db_estado), 32'h2);
    send(7'h30, 2); send(7'h31, 2);
    tick(1'b1, 7'h23);
    chk("t4_medida2", 32'(medida), 32'h501);
    chk("t4_erros", 32'(db_erros), 32'h2);
    tick(1'b0, 7'h00);

    // Reset mid-frame
    send(7'h34, 2); send(7'h35, 2);
    reset = 1'b0;
    #2;
    model_reset();
    chk("t5_medida", 32'(medida), 32'h000);
    chk("t5_estado", 32'(db_estado), 32'h0);
    chk("t5_erros", 32'(db_erros), 32'h0);
    #1 reset = 1'b1;
    #1;
    chk("t5_estado_pos", 32'(db_estado), 32'h0);
    tick(1'b0, 7'h00);
    send(7'h32, 1); send(7'h34, 0); send(7'h36, 4);
    tick(1'b1, 7'h23);
    chk("t5_medida2", 32'(medida), 32'h246);

    // Error counter saturation, then char on the timeout cycle
    for (int i = 0; i < 16; i++) send(7'h58, 1);
    chk("t6_saturado", 32'(db_erros), 32'hF);
    tick(1'b1, 7'h33);
    repeat (c_TO - 1) tick(1'b0, 7'h00);
    tick(1'b1, 7'h31);
    chk("t6_aceito", 32'(db_estado), 32'h3);
    chk("t6_sem_erro", 32'(erro), 32'h0);
    send(7'h37, 0);
    tick(1'b1, 7'h23);
    chk("t6_medida", 32'(medida), 32'h317);
    chk("t6_erros", 32'(db_erros), 32'hF);

    // Random traffic with gaps that sometimes exceed the timeout
    reset = 1'b0;
    #2;
    model_reset();
    #1 reset = 1'b1;
    tick(1'b0, 7'h00);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6: ch = 7'h30 + 7'($urandom_range(0, 9));
        7:                   ch = 7'h23;
        8:                   ch = 7'h58;
        default:             ch = 7'($urandom);
      endcase
      send(ch, (($urandom_range(0, 7) == 0) ? $urandom_range(15, 22) : $urandom_range(0, 4)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
